// File: rtl/ufi_write_buffer.sv
// ufi_write_buffer
//   Decouples the SPI-slave Ufi write stream from the PSRAM controller. Each
//   written word is queued with its byte address; once a full burst is
//   queued, or the transfer window closes with words still waiting, a burst
//   request is raised and the queued words are streamed out on ack.
//
// Ports
//   iSysClk, iSysRst   : system clock (rising edge), async active-low reset
//   iMUfiWd/iMUfiAdrs  : incoming word and its byte address
//   iMUfiWEd           : one word per high cycle
//   iMUfiWVd           : transfer window; its falling edge requests a flush
//   oPsReq/oPsAdrs/oPsLen, iPsGnt : burst request handshake
//   oPsWd/oPsWVd, iPsWAck         : burst data stream (FIFO head)
//   oOverflow, iOvfClr : sticky drop indicator and its clear
//   oBusy              : words queued or a burst in progress
module ufi_write_buffer #(
  parameter int pFifoDepth = 16,
  parameter int pBurstLen  = 8
) (
  input  logic        iSysClk,
  input  logic        iSysRst,
  input  logic [31:0] iMUfiWd,
  input  logic [31:0] iMUfiAdrs,
  input  logic        iMUfiWEd,
  input  logic        iMUfiWVd,
  output logic        oPsReq,
  output logic [31:0] oPsAdrs,
  output logic [7:0]  oPsLen,
  input  logic        iPsGnt,
  output logic [31:0] oPsWd,
  output logic        oPsWVd,
  input  logic        iPsWAck,
  output logic        oOverflow,
  input  logic        iOvfClr,
  output logic        oBusy
);

  localparam int cPtrW = $clog2(pFifoDepth);
  localparam int cCntW = cPtrW + 1;
  localparam logic [cCntW-1:0] cDepth = cCntW'(pFifoDepth);
  localparam logic [cCntW-1:0] cBurst = cCntW'(pBurstLen);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} tState;

  tState            rState, wNextState;
  logic [63:0]      rFifo [pFifoDepth];
  logic [cPtrW-1:0] rWrPtr, rRdPtr;
  logic [cCntW-1:0] rCount;
  logic [7:0]       rRemain;
  logic [7:0]       rPsLen;
  logic [31:0]      rPsAdrs;
  logic             rFlushPend, rWVdQ, rOverflow;
  logic             wFull, wPush, wPop, wDrop, wStart;
  logic [63:0]      wHead;

  // Burst length is whatever is queued, capped at the maximum burst size.
  function automatic logic [7:0] burstLen(input logic [cCntW-1:0] cnt);
    if (cnt >= cBurst) return 8'(cBurst);
    return 8'(cnt);
  endfunction

  assign wFull  = (rCount == cDepth);
  assign wPop   = (rState == XFER) && iPsWAck;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wPush  = iMUfiWEd && (!wFull || wPop);
  assign wDrop  = iMUfiWEd && wFull && !wPop;
  assign wHead  = rFifo[rRdPtr];
  assign wStart = (rState == IDLE) &&
                  ((rCount >= cBurst) || (rFlushPend && (rCount != '0)));

  // Entry storage carries no reset; only valid entries are ever read.
  always_ff @(posedge iSysClk) begin
    if (wPush) rFifo[rWrPtr] <= {iMUfiAdrs, iMUfiWd};
  end

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      rState     <= IDLE;
      rWrPtr     <= '0;
      rRdPtr     <= '0;
      rCount     <= '0;
      rRemain    <= '0;
      rPsLen     <= '0;
      rPsAdrs    <= '0;
      rFlushPend <= 1'b0;
      rWVdQ      <= 1'b0;
      rOverflow  <= 1'b0;
    end else begin
      rState <= wNextState;
      if (wPush) rWrPtr <= rWrPtr + cPtrW'(1);
      if (wPop)  rRdPtr <= rRdPtr + cPtrW'(1);
      rCount <= rCount + cCntW'(wPush) - cCntW'(wPop);

      rWVdQ <= iMUfiWVd;
      if (rWVdQ && !iMUfiWVd)
        rFlushPend <= 1'b1;
      else if ((rCount == '0) && (rState == IDLE))
        rFlushPend <= 1'b0;

      // Set has priority over clear so a drop is never lost.
      if (wDrop)        rOverflow <= 1'b1;
      else if (iOvfClr) rOverflow <= 1'b0;

      if (wStart) begin
        rPsLen  <= burstLen(rCount);
        rPsAdrs <= wHead[63:32];
        rRemain <= burstLen(rCount);
      end else if (wPop) begin
        rRemain <= rRemain - 8'd1;
      end
    end
  end

  always_comb begin
    wNextState = rState;
    oPsReq     = 1'b0;
    oPsWVd     = 1'b0;
    oPsWd      = '0;
    case (rState)
      IDLE: if (wStart) wNextState = REQ;
      REQ: begin
        oPsReq = 1'b1;
        if (iPsGnt) wNextState = XFER;
      end
      XFER: begin
        oPsWVd = 1'b1;
        oPsWd  = wHead[31:0];
        if (wPop && (rRemain == 8'd1)) wNextState = IDLE;
      end
      default: wNextState = IDLE;
    endcase
  end

  assign oPsAdrs   = rPsAdrs;
  assign oPsLen    = rPsLen;
  assign oOverflow = rOverflow;
  assign oBusy     = (rCount != '0) || (rState != IDLE);

endmodule

// File: doc/ufi_write_buffer.md
UFI_WRITE_BUFFER -- requirements
Module: ufi_write_buffer

Interface
REQ-001 SHALL have parameter pFifoDepth, default 16, meaning entry count; power of two, minimum 4.
REQ-002 SHALL have parameter pBurstLen, default 8, meaning maximum words per PSRAM burst; 1 to pFifoDepth.
REQ-003 SHALL have port iSysClk, input, 1 bit, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port iSysRst, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port iMUfiWd, input, 32 bits, write data from the SPI slave Ufi master.
REQ-006 SHALL have port iMUfiAdrs, input, 32 bits, byte address of iMUfiWd.
REQ-007 SHALL have port iMUfiWEd, input, 1 bit, write-data-enable strobe; one word per high cycle.
REQ-008 SHALL have port iMUfiWVd, input, 1 bit, high for the whole transfer window.
REQ-009 SHALL have port oPsReq, output, 1 bit, burst request to the PSRAM controller.
REQ-010 SHALL have port oPsAdrs, output, 32 bits, burst start byte address.
REQ-011 SHALL have port oPsLen, output, 8 bits, burst word count.
REQ-012 SHALL have port iPsGnt, input, 1 bit, single-cycle grant pulse.
REQ-013 SHALL have port oPsWd, output, 32 bits, burst data (the FIFO head).
REQ-014 SHALL have port oPsWVd, output, 1 bit, oPsWd valid.
REQ-015 SHALL have port iPsWAck, input, 1 bit, word accepted.
REQ-016 SHALL have port oOverflow, output, 1 bit, sticky flag set when a word is dropped.
REQ-017 SHALL have port iOvfClr, input, 1 bit, clears oOverflow.
REQ-018 SHALL have port oBusy, output, 1 bit, high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-019 SHALL store {iMUfiAdrs, iMUfiWd} as one 64-bit FIFO entry on each cycle where iMUfiWEd=1 and the FIFO is not full.
REQ-020 SHALL accept a push while full only when a pop occurs in the same cycle; otherwise SHALL drop the word and set oOverflow the next cycle.
REQ-021 SHALL keep oOverflow set until an iOvfClr cycle; if set and clear coincide, set SHALL win.
REQ-022 SHALL hold count with width log2(pFifoDepth)+1; read and write pointers SHALL wrap modulo pFifoDepth.
REQ-023 SHALL set flush-pending on the iMUfiWVd 1->0 edge; flush-pending SHALL clear when the FIFO is empty and the FSM is in IDLE.
REQ-024 SHALL implement FSM states IDLE, REQ and XFER.
REQ-025 IDLE->REQ SHALL occur when count>=pBurstLen, or when flush-pending=1 and count>0.
REQ-026 On IDLE->REQ, SHALL latch oPsLen=min(count,pBurstLen) and oPsAdrs=head address.
REQ-027 In REQ, SHALL hold oPsReq=1 with stable oPsAdrs/oPsLen until iPsGnt=1, then go to XFER with oPsReq=0 the next cycle.
REQ-028 In XFER, SHALL drive oPsWVd=1 and oPsWd=FIFO head; each iPsWAck=1 SHALL pop one entry and decrement remaining.
REQ-029 On the ack of the last word, XFER->IDLE; oPsWVd SHALL be 0 the following cycle.
REQ-030 SHALL ignore iPsWAck outside XFER and iPsGnt outside REQ.
REQ-031 SHALL need at most 1 idle cycle between back-to-back bursts.
REQ-032 SHALL NOT check address contiguity within a burst; the upstream guarantees +4 increments.

Reset
REQ-033 On iSysRst=0, asynchronously and regardless of FSM state, SHALL clear pointers, count, flush-pending and oOverflow, set the FSM to IDLE, and drive oPsReq=0, oPsWVd=0, oPsAdrs=0, oPsLen=0, oPsWd=0, oBusy=0.
REQ-034 A reset mid-burst SHALL discard all buffered data; after release, no request SHALL be made until new words arrive.

Verification
REQ-035 Bench SHALL cover: 8 words from 0x100 with data 1..8, gnt 2 cycles after req, ack every cycle -> one burst with oPsAdrs=0x100, oPsLen=8, data 1..8 in order.
REQ-036 Bench SHALL cover: 3 words at 0x200 then iMUfiWVd falls -> burst with oPsLen=3, then oBusy=0.
REQ-037 Bench SHALL cover: 17 words with no grant (depth 16) -> 17th word dropped, oOverflow=1 until iOvfClr, first 16 words delivered intact.
REQ-038 Bench SHALL cover: 20 words streamed while acks alternate 1/0 -> bursts of 8, 8 and 4 (after WVd falls), with addresses +0x20 per burst.
REQ-039 Bench SHALL cover: reset asserted in XFER after 3 acks -> all outputs 0 immediately; after release, no oPsReq is issued.
REQ-040 Bench SHALL cover: push while full with simultaneous ack -> word accepted, oOverflow stays 0.
